// File: rtl/rhd2000_pkg.sv
// Shared definitions for the RHD2000 SPI master, the rhd2000_dm data model and their benches:
// FSM state encoding, command opcodes and a command-word builder.
package rhd2000_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_e;

    localparam logic [1:0] CONVERT   = 2'b00;
    localparam logic [7:0] CALIBRATE = 8'b0101_0101;
    localparam logic [7:0] CLEAR     = 8'b0110_1010;
    localparam logic [1:0] WRITE     = 2'b10;
    localparam logic [1:0] READ      = 2'b11;

    function automatic logic [15:0] build_cmd(input logic [1:0] opcode,
                                              input logic [5:0] addr,
                                              input logic [7:0] data);
        return {opcode, addr, data};
    endfunction

endpackage

// File: rtl/rhd2000_cmd_history.sv
// Shift history of issued commands; the oldest entry is the command whose result
// the chip returns in the current transaction.
module rhd2000_cmd_history #(
    parameter int PIPE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [15:0] cmd,
    output logic [15:0] oldest,
    output logic        filled
);

    localparam int                FILL_W   = $clog2(PIPE_DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PIPE_DEPTH);

    logic [15:0]       hist_r [PIPE_DEPTH];
    logic [FILL_W-1:0] fill_r;

    // History shift and saturating fill count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                hist_r[i] <= 16'h0000;
            end
            fill_r <= {FILL_W{1'b0}};
        end else if (push) begin
            hist_r[0] <= cmd;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                hist_r[i] <= hist_r[i-1];
            end
            if (fill_r != FILL_MAX) begin
                fill_r <= fill_r + FILL_W'(1);
            end
        end
    end

    assign oldest = hist_r[PIPE_DEPTH-1];
    assign filled = (fill_r >= FILL_MAX);

endmodule

// File: rtl/rhd2000_spi_master.sv
// SPI mode-0 master for RHD2000-class chips: one 16-bit command per frame, captured
// MISO word returned tagged with the command that produced it.
module rhd2000_spi_master
    import rhd2000_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int CS_HIGH_CYCLES = 8,
    parameter int PIPE_DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [15:0] cmdData,
    output logic        rspValid,
    output logic [15:0] rspData,
    output logic [15:0] rspCmd,
    output logic        rspCmdValid,
    output logic        busy,
    output logic        nCs,
    output logic        sClk,
    output logic        mosi,
    input  logic        miso
);

    localparam int               CNT_MAX   = (CLK_DIV > CS_HIGH_CYCLES) ? CLK_DIV : CS_HIGH_CYCLES;
    localparam int               CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_HIGH_CYCLES - 1);
    localparam logic [4:0]       BITS_LAST = 5'd16;

    spi_state_e       state_r, state_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic [4:0]       bit_r, bit_nxt;
    logic [15:0]      shift_r, shift_nxt;
    logic [15:0]      cmd_r, cmd_nxt;
    logic [15:0]      rx_r, rx_nxt;
    logic             ncs_nxt, sclk_nxt, mosi_nxt;
    logic             rsp_fire_s;
    logic             div_done_s, gap_done_s;
    logic [15:0]      hist_oldest_s;
    logic             hist_filled_s;

    assign div_done_s = (cnt_r == DIV_LAST);
    assign gap_done_s = (cnt_r == GAP_LAST);

    // Next-state and next-pin-value logic; pins are registered so they change on state entry.
    always_comb begin
        state_nxt  = state_r;
        cnt_nxt    = cnt_r;
        bit_nxt    = bit_r;
        shift_nxt  = shift_r;
        cmd_nxt    = cmd_r;
        rx_nxt     = rx_r;
        ncs_nxt    = nCs;
        sclk_nxt   = sClk;
        mosi_nxt   = mosi;
        rsp_fire_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt = CNT_ZERO;
                if (cmdValid && cmdReady) begin
                    state_nxt = SETUP;
                    bit_nxt   = 5'd0;
                    shift_nxt = cmdData;
                    cmd_nxt   = cmdData;
                    rx_nxt    = 16'h0000;
                    ncs_nxt   = 1'b0;
                    sclk_nxt  = 1'b0;
                    mosi_nxt  = cmdData[15];
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETUP: begin
                if (div_done_s) begin
                    state_nxt = LOW;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            LOW: begin
                if (div_done_s) begin
                    state_nxt = HIGH;
                    cnt_nxt   = CNT_ZERO;
                    sclk_nxt  = 1'b1;
                    rx_nxt    = {rx_r[14:0], miso};
                    bit_nxt   = bit_r + 5'd1;
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            HIGH: begin
                if (div_done_s) begin
                    cnt_nxt  = CNT_ZERO;
                    sclk_nxt = 1'b0;
                    if (bit_r == BITS_LAST) begin
                        state_nxt = HOLD;
                    end else begin
                        // falling edge: present the next command bit
                        state_nxt = LOW;
                        shift_nxt = {shift_r[14:0], 1'b0};
                        mosi_nxt  = shift_r[14];
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            HOLD: begin
                if (div_done_s) begin
                    state_nxt  = GAP;
                    cnt_nxt    = CNT_ZERO;
                    ncs_nxt    = 1'b1;
                    mosi_nxt   = 1'b0;
                    rsp_fire_s = 1'b1;
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            GAP: begin
                if (gap_done_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = CNT_ZERO;
                ncs_nxt   = 1'b1;
                sclk_nxt  = 1'b0;
                mosi_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state, datapath and pin registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            bit_r    <= 5'd0;
            shift_r  <= 16'h0000;
            cmd_r    <= 16'h0000;
            rx_r     <= 16'h0000;
            nCs      <= 1'b1;
            sClk     <= 1'b0;
            mosi     <= 1'b0;
            cmdReady <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            cnt_r    <= cnt_nxt;
            bit_r    <= bit_nxt;
            shift_r  <= shift_nxt;
            cmd_r    <= cmd_nxt;
            rx_r     <= rx_nxt;
            nCs      <= ncs_nxt;
            sClk     <= sclk_nxt;
            mosi     <= mosi_nxt;
            cmdReady <= (state_nxt == IDLE);
            busy     <= (state_nxt != IDLE);
        end
    end

    // Response registers, loaded as the frame closes (history read before this frame's push).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rspValid    <= 1'b0;
            rspData     <= 16'h0000;
            rspCmd      <= 16'h0000;
            rspCmdValid <= 1'b0;
        end else begin
            rspValid <= rsp_fire_s;
            if (rsp_fire_s) begin
                rspData     <= rx_r;
                rspCmd      <= hist_oldest_s;
                rspCmdValid <= hist_filled_s;
            end
        end
    end

    rhd2000_cmd_history #(
        .PIPE_DEPTH(PIPE_DEPTH)
    ) u_history (
        .clk    (clk),
        .rst    (reset),
        .push   (rsp_fire_s),
        .cmd    (cmd_r),
        .oldest (hist_oldest_s),
        .filled (hist_filled_s)
    );

endmodule
